// File: rtl/uart_frame_packer.sv
// uart_frame_packer: buffers 32-bit words in a FIFO and emits sync + LSB-first payload bytes to an 8N1 transmitter.
// Define UART_FRAME_PACKER_CHECKSUM_EN to append an 8-bit modulo-256 payload checksum byte.
module uart_frame_packer #(
  parameter int BYTE_W = 8,
  parameter int WORD_BYTES = 4,
  parameter int FIFO_DEPTH = 4,
  parameter logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5
) (
  input  logic                           sys_clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [WORD_BYTES*BYTE_W-1:0]   in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [BYTE_W-1:0]              tx_data,
  output logic                           tx_load,
  input  logic                           tx_load_ok,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
  output logic                           busy
);
  localparam int WW = WORD_BYTES * BYTE_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(WORD_BYTES + 2);
`ifdef UART_FRAME_PACKER_CHECKSUM_EN
  localparam int LAST = WORD_BYTES + 1;
`else
  localparam int LAST = WORD_BYTES;
`endif
  typedef enum logic [1:0] {IDLE, WAIT_OK, HOLD} state_t;
  state_t r_state, w_next;
  logic [WW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [WW-1:0] r_word;
  logic [IW-1:0] r_idx;
  logic [BYTE_W-1:0] r_tx_data;
  logic r_tx_load;
  logic w_push, w_pop, w_load, w_last;
  logic [BYTE_W-1:0] w_pay, w_byte;

  assign in_ready = r_count != CW'(FIFO_DEPTH);
  assign w_push = in_valid && in_ready;
  assign w_pop = r_state == IDLE && enable && r_count != '0;
  assign w_load = r_state == WAIT_OK && enable && tx_load_ok;
  assign w_last = r_idx == IW'(LAST);
  // idx 0 is the sync byte, so payload byte n sits at idx n+1
  assign w_pay = BYTE_W'(r_word >> (BYTE_W * (int'(r_idx) - 1)));
  assign tx_data = r_tx_data;
  assign tx_load = r_tx_load;
  assign fifo_count = r_count;
  assign busy = r_state != IDLE;

`ifdef UART_FRAME_PACKER_CHECKSUM_EN
  logic [BYTE_W-1:0] r_sum;
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) r_sum <= '0;
    else if (r_state == IDLE) r_sum <= '0;
    else if (w_load && r_idx != '0 && !w_last) r_sum <= r_sum + w_pay;
  assign w_byte = r_idx == '0 ? SYNC_BYTE : w_last ? r_sum : w_pay;
`else
  assign w_byte = r_idx == '0 ? SYNC_BYTE : w_pay;
`endif

  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end

  always_ff @(posedge sys_clk)
    if (w_push) r_mem[r_wr_ptr] <= in_data;

  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_word <= '0;
      r_idx <= '0;
      r_tx_data <= '0;
      r_tx_load <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tx_load <= w_load;
      if (w_pop) begin
        r_word <= r_mem[r_rd_ptr];
        r_idx <= '0;
      end
      if (w_load) r_tx_data <= w_byte;
      if (r_state == HOLD && !w_last) r_idx <= r_idx + 1'b1;
    end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_pop ? WAIT_OK : IDLE;
      WAIT_OK: w_next = w_load ? HOLD : WAIT_OK;
      HOLD:    w_next = w_last ? IDLE : WAIT_OK;
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_frame_packer.sv
// tb_uart_frame_packer: directed bench for uart_frame_packer with a simple transmitter TX_LOAD_OKAY model.
module tb_uart_frame_packer;
`ifdef UART_FRAME_PACKER_CHECKSUM_EN
  localparam int FL = 6;
`else
  localparam int FL = 5;
`endif
  logic sys_clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  logic [31:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] tx_data;
  logic tx_load;
  logic tx_load_ok;
  logic [2:0] fifo_count;
  logic busy;

  int checks = 0;
  int errors = 0;
  int gap = 4;
  int tx_busy = 0;
  bit tx_hold = 1'b0;
  int dbl_cnt = 0;
  bit prev_load = 1'b0;
  logic [7:0] cap_q[$];

  uart_frame_packer dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .tx_data(tx_data), .tx_load(tx_load),
    .tx_load_ok(tx_load_ok), .fifo_count(fifo_count), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  // transmitter: drops TX_LOAD_OKAY from the edge that samples TX_LOAD, for gap cycles
  always @(posedge sys_clk or negedge rst_n)
    if (!rst_n) tx_busy <= 0;
    else if (tx_load) tx_busy <= gap;
    else if (tx_busy != 0) tx_busy <= tx_busy - 1;
  assign tx_load_ok = !tx_hold && tx_busy == 0;

  always @(negedge sys_clk) begin
    if (tx_load) cap_q.push_back(tx_data);
    if (tx_load && prev_load) dbl_cnt++;
    prev_load = tx_load;
  end

  function automatic logic [7:0] exp_byte(logic [31:0] w, int k);
    if (k == 0) return 8'hA5;
    if (k <= 4) return w[8*(k-1) +: 8];
    return w[7:0] + w[15:8] + w[23:16] + w[31:24];
  endfunction

  function automatic logic [7:0] got_byte(int i);
    return i < cap_q.size() ? cap_q[i] : 8'hxx;
  endfunction

  function automatic int first_bad(int base, logic [31:0] w);
    for (int k = 0; k < FL; k++)
      if (base + k >= cap_q.size() || cap_q[base + k] !== exp_byte(w, k)) return k;
    return -1;
  endfunction

  task automatic push(input logic [31:0] w);
    @(negedge sys_clk);
    in_data = w;
    in_valid = 1'b1;
    @(negedge sys_clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n);
    for (int c = 0; c < 3000 && cap_q.size() < n; c++) begin
      @(negedge sys_clk);
      #1;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge sys_clk);
    checks++; if (tx_load !== 1'b0) begin errors++; $display("FAIL rst_tx_load got %b exp 0", tx_load); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h exp 00", tx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_fifo_count got %0d exp 0", fifo_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int fb;
    cap_q.delete();
    dbl_cnt = 0;
    push(32'h12345678);
    @(negedge sys_clk); #1;
    checks++; if (tx_load !== 1'b0) begin errors++; $display("FAIL lat_early got %b exp 0", tx_load); end
    @(negedge sys_clk); #1;
    checks++; if (tx_load !== 1'b1) begin errors++; $display("FAIL lat_strobe got %b exp 1", tx_load); end
    wait_bytes(FL);
    fb = first_bad(0, 32'h12345678);
    checks++; if (fb !== -1) begin errors++; $display("FAIL basic_frame byte %0d got %h exp %h", fb, got_byte(fb), exp_byte(32'h12345678, fb)); end
    @(negedge sys_clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fall got %b exp 0", busy); end
    checks++; if (dbl_cnt !== 0) begin errors++; $display("FAIL basic_strobe_width got %0d long strobes exp 0", dbl_cnt); end
`ifdef UART_FRAME_PACKER_CHECKSUM_EN
    checks++; if (got_byte(5) !== 8'h14) begin errors++; $display("FAIL csum_12345678 got %h exp 14", got_byte(5)); end
`endif
    cap_q.delete();
    push(32'hFFFFFFFF);
    wait_bytes(FL);
    fb = first_bad(0, 32'hFFFFFFFF);
    checks++; if (fb !== -1) begin errors++; $display("FAIL ones_frame byte %0d got %h exp %h", fb, got_byte(fb), exp_byte(32'hFFFFFFFF, fb)); end
`ifdef UART_FRAME_PACKER_CHECKSUM_EN
    checks++; if (got_byte(5) !== 8'hFC) begin errors++; $display("FAIL csum_ffffffff got %h exp FC", got_byte(5)); end
`endif
    repeat (10) @(negedge sys_clk);
  endtask

  task automatic test_backpressure;
    logic [31:0] w [5] = '{32'h11223344, 32'hA0B0C0D0, 32'h01020304, 32'hDEADBEEF, 32'hCAFEF00D};
    int n_acc = 0;
    bit last_acc = 1'b0;
    int fb;
    cap_q.delete();
    enable = 1'b0;
    tx_hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge sys_clk);
      in_data = w[k];
      in_valid = 1'b1;
      last_acc = in_ready;
      if (in_ready) n_acc++;
    end
    @(negedge sys_clk);
    in_valid = 1'b0;
    #1;
    checks++; if (n_acc !== 4) begin errors++; $display("FAIL bp_accepted got %0d exp 4", n_acc); end
    checks++; if (last_acc !== 1'b0) begin errors++; $display("FAIL bp_fifth_refused got %b exp 0", last_acc); end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL bp_fifo_count got %0d exp 4", fifo_count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
    enable = 1'b1;
    repeat (10) @(negedge sys_clk);
    #1;
    checks++; if (cap_q.size() !== 0) begin errors++; $display("FAIL bp_held_strobes got %0d exp 0", cap_q.size()); end
    tx_hold = 1'b0;
    wait_bytes(4 * FL);
    repeat (200) @(negedge sys_clk);
    #1;
    checks++; if (cap_q.size() !== 4 * FL) begin errors++; $display("FAIL bp_byte_count got %0d exp %0d", cap_q.size(), 4 * FL); end
    for (int f = 0; f < 4; f++) begin
      fb = first_bad(f * FL, w[f]);
      checks++; if (fb !== -1) begin errors++; $display("FAIL bp_frame%0d byte %0d got %h exp %h", f, fb, got_byte(f * FL + fb), exp_byte(w[f], fb)); end
    end
  endtask

  task automatic test_enable_gating;
    int fb;
    cap_q.delete();
    push(32'h0BADCAFE);
    wait_bytes(2);
    enable = 1'b0;
    repeat (50) @(negedge sys_clk);
    #1;
    checks++; if (cap_q.size() !== 2) begin errors++; $display("FAIL en_gated_strobes got %0d exp 2", cap_q.size()); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL en_parked_busy got %b exp 1", busy); end
    enable = 1'b1;
    wait_bytes(FL);
    fb = first_bad(0, 32'h0BADCAFE);
    checks++; if (fb !== -1) begin errors++; $display("FAIL en_frame byte %0d got %h exp %h", fb, got_byte(fb), exp_byte(32'h0BADCAFE, fb)); end
    repeat (10) @(negedge sys_clk);
  endtask

  task automatic test_reset_mid;
    int fb;
    cap_q.delete();
    gap = 3;
    push(32'h11111111);
    push(32'h22222222);
    push(32'h33333333);
    wait_bytes(2);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (tx_load !== 1'b0) begin errors++; $display("FAIL rmid_tx_load got %b exp 0", tx_load); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rmid_fifo_count got %0d exp 0", fifo_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
    @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (40) @(negedge sys_clk);
    #1;
    checks++; if (cap_q.size() !== 2) begin errors++; $display("FAIL rmid_no_strobes got %0d exp 2", cap_q.size()); end
    push(32'h89ABCDEF);
    wait_bytes(2 + FL);
    fb = first_bad(2, 32'h89ABCDEF);
    checks++; if (fb !== -1) begin errors++; $display("FAIL rmid_new_frame byte %0d got %h exp %h", fb, got_byte(2 + fb), exp_byte(32'h89ABCDEF, fb)); end
    repeat (10) @(negedge sys_clk);
  endtask

  task automatic test_back_to_back;
    int fb;
    cap_q.delete();
    gap = 1;
    dbl_cnt = 0;
    push(32'h55AA00FF);
    push(32'h80402010);
    wait_bytes(2 * FL);
    repeat (20) @(negedge sys_clk);
    #1;
    checks++; if (cap_q.size() !== 2 * FL) begin errors++; $display("FAIL b2b_byte_count got %0d exp %0d", cap_q.size(), 2 * FL); end
    checks++; if (dbl_cnt !== 0) begin errors++; $display("FAIL b2b_double_load got %0d exp 0", dbl_cnt); end
    fb = first_bad(0, 32'h55AA00FF);
    checks++; if (fb !== -1) begin errors++; $display("FAIL b2b_frame0 byte %0d got %h exp %h", fb, got_byte(fb), exp_byte(32'h55AA00FF, fb)); end
    fb = first_bad(FL, 32'h80402010);
    checks++; if (fb !== -1) begin errors++; $display("FAIL b2b_frame1 byte %0d got %h exp %h", fb, got_byte(FL + fb), exp_byte(32'h80402010, fb)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_enable_gating();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
